// File: rtl/qm_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, the long-latency
// unit retires when the port is free, and a pending scoreboard stalls issue on hazards.
module qm_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pl_we,
  input  logic [4:0]       pl_wa,
  input  logic [WIDTH-1:0] pl_wd,
  output logic             pl_hold,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [4:0]       lu_wa,
  input  logic [WIDTH-1:0] lu_wd,
  input  logic             iss_alloc,
  input  logic [4:0]       iss_wa,
  input  logic [4:0]       q_ra1,
  input  logic [4:0]       q_ra2,
  input  logic [4:0]       q_wa,
  output logic             iss_stall,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             proto_err
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             pl_req;
  logic             lu_acc;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_wa_q, rf_wa_d;
  logic [WIDTH-1:0] rf_wd_q, rf_wd_d;
  logic [31:1]      pending_q, pending_d;
  logic [31:0]      pend_full;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             proto_err_q, proto_err_d;

  // Arbitration: pipeline requests to r0 never claim the port.
  assign pl_req   = pl_we & (pl_wa != 5'd0);
  assign lu_ready = ~pl_req;
  assign lu_acc   = lu_valid & ~pl_req;

  // pl_hold decodes registered state only, so the pipeline sees it without an input path.
  assign pl_hold  = (starve_cnt_q == CNT_MAX);

  assign pend_full = {pending_q, 1'b0};
  assign iss_stall = pend_full[q_ra1] | pend_full[q_ra2] | pend_full[q_wa];

  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (pl_req) begin
      rf_we_d = 1'b1;
      rf_wa_d = pl_wa;
      rf_wd_d = pl_wd;
    end else if (lu_valid) begin
      rf_we_d = (lu_wa != 5'd0);
      rf_wa_d = lu_wa;
      rf_wd_d = lu_wd;
    end
  end

  // Set beats clear when an issue and a retirement target the same register.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (lu_acc && (lu_wa == 5'(i)))
        pending_d[i] = 1'b0;
      if (iss_alloc && (iss_wa == 5'(i)))
        pending_d[i] = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!lu_valid || lu_acc)
      starve_cnt_d = '0;
    else
      starve_cnt_d = sat_inc(starve_cnt_q);
  end

  assign proto_err_d = proto_err_q | (pl_we & pl_hold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 5'd0;
      rf_wd_q      <= '0;
      pending_q    <= '0;
      starve_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_qm_wb_arbiter.sv
// Directed bench for qm_wb_arbiter: hand-computed vectors for commit, scoreboard,
// starvation guard, protocol error and asynchronous reset.
module tb_qm_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pl_we;
  logic [4:0]  pl_wa;
  logic [31:0] pl_wd;
  logic        pl_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        iss_alloc;
  logic [4:0]  iss_wa;
  logic [4:0]  q_ra1, q_ra2, q_wa;
  logic        iss_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        proto_err;

  int n_vec  = 0;
  int n_miss = 0;

  qm_wb_arbiter #(.WIDTH(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .pl_we(pl_we), .pl_wa(pl_wa), .pl_wd(pl_wd), .pl_hold(pl_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .iss_alloc(iss_alloc), .iss_wa(iss_wa),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_wa(q_wa), .iss_stall(iss_stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issuing into a pending hazard is illegal stimulus.
  always @(negedge clk) begin
    if (!reset && iss_alloc && iss_stall) begin
      n_miss++;
      $display("FAIL alloc_while_stall: iss_alloc=1 with iss_stall=1");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pl_we = 0; pl_wa = 0; pl_wd = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0;
    iss_alloc = 0; iss_wa = 0; q_ra1 = 0; q_ra2 = 0; q_wa = 0;
    #1;
    chk_vec("rst_rf_we", rf_we, 0);
    chk_vec("rst_rf_wa", rf_wa, 0);
    chk_vec("rst_rf_wd", rf_wd, 0);
    chk_vec("rst_lu_ready", lu_ready, 1);
    chk_vec("rst_iss_stall", iss_stall, 0);
    chk_vec("rst_pl_hold", pl_hold, 0);
    chk_vec("rst_proto_err", proto_err, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: pipeline write, then write to r0
    pl_we = 1; pl_wa = 5; pl_wd = 32'hDEADBEEF;
    #1 chk_vec("t1_lu_ready_blocked", lu_ready, 0);
    tick();
    chk_vec("t1_rf_we", rf_we, 1);
    chk_vec("t1_rf_wa", rf_wa, 5);
    chk_vec("t1_rf_wd", rf_wd, 32'hDEADBEEF);
    pl_wa = 0; pl_wd = 32'h11111111;
    #1 chk_vec("t1_r0_lu_ready", lu_ready, 1);
    tick();
    chk_vec("t1_r0_rf_we", rf_we, 0);
    chk_vec("t1_r0_rf_wa_hold", rf_wa, 5);
    chk_vec("t1_r0_rf_wd_hold", rf_wd, 32'hDEADBEEF);
    pl_we = 0;

    // 2: scoreboard set, hazard stall, LU retire clears it
    iss_alloc = 1; iss_wa = 7;
    tick();
    iss_alloc = 0; q_ra1 = 7;
    #1 chk_vec("t2_stall_ra1", iss_stall, 1);
    q_ra1 = 0; q_wa = 7;
    #1 chk_vec("t2_stall_wa", iss_stall, 1);
    q_wa = 0; q_ra1 = 7;
    lu_valid = 1; lu_wa = 7; lu_wd = 32'h1234;
    #1 chk_vec("t2_lu_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    chk_vec("t2_rf_we", rf_we, 1);
    chk_vec("t2_rf_wa", rf_wa, 7);
    chk_vec("t2_rf_wd", rf_wd, 32'h1234);
    chk_vec("t2_stall_clear", iss_stall, 0);
    q_ra1 = 0;

    // 3: starvation guard
    pl_we = 1; pl_wa = 3; pl_wd = 32'hAAAA;
    lu_valid = 1; lu_wa = 9; lu_wd = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_vec($sformatf("t3_lu_ready_c%0d", i), lu_ready, 0);
      chk_vec($sformatf("t3_pl_hold_c%0d", i), pl_hold, 0);
      tick();
    end
    chk_vec("t3_pl_hold_4th", pl_hold, 1);
    chk_vec("t3_rf_wa_pl", rf_wa, 3);
    pl_we = 0;
    #1 chk_vec("t3_lu_ready_after_drop", lu_ready, 1);
    tick();
    chk_vec("t3_rf_we_lu", rf_we, 1);
    chk_vec("t3_rf_wa_lu", rf_wa, 9);
    chk_vec("t3_rf_wd_lu", rf_wd, 32'h9999);
    chk_vec("t3_pl_hold_drop", pl_hold, 0);
    chk_vec("t3_no_proto_err", proto_err, 0);

    // 4: pipeline ignores pl_hold -> still wins, proto_err sticks
    pl_we = 1; pl_wa = 11; pl_wd = 32'h1111;
    lu_valid = 1; lu_wa = 10; lu_wd = 32'h55;
    tick(); tick(); tick();
    chk_vec("t4_pl_hold", pl_hold, 1);
    pl_wa = 12; pl_wd = 32'h2222;
    #1 chk_vec("t4_lu_ready", lu_ready, 0);
    tick();
    chk_vec("t4_rf_wa_pl", rf_wa, 12);
    chk_vec("t4_rf_wd_pl", rf_wd, 32'h2222);
    chk_vec("t4_proto_err", proto_err, 1);
    chk_vec("t4_pl_hold_sat", pl_hold, 1);
    pl_we = 0;
    tick();
    chk_vec("t4_rf_wa_lu", rf_wa, 10);
    chk_vec("t4_rf_wd_lu", rf_wd, 32'h55);
    chk_vec("t4_pl_hold_drop", pl_hold, 0);
    lu_valid = 0;
    tick();
    chk_vec("t4_proto_err_sticky", proto_err, 1);

    // 5: r0 as scoreboard target and LU destination
    iss_alloc = 1; iss_wa = 0;
    tick();
    iss_alloc = 0;
    #1 chk_vec("t5_no_r0_pending", iss_stall, 0);
    lu_valid = 1; lu_wa = 0; lu_wd = 32'h77;
    #1 chk_vec("t5_lu_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    chk_vec("t5_rf_we_r0", rf_we, 0);
    chk_vec("t5_rf_wd_r0", rf_wd, 32'h77);

    // set beats clear on the same register
    iss_alloc = 1; iss_wa = 13;
    tick();
    iss_alloc = 1; iss_wa = 13; lu_valid = 1; lu_wa = 13; lu_wd = 32'hC0DE;
    tick();
    iss_alloc = 0; lu_valid = 0; q_ra2 = 13;
    #1 chk_vec("set_wins_stall", iss_stall, 1);
    chk_vec("set_wins_rf_wa", rf_wa, 13);
    q_ra2 = 0;

    // 6: async reset mid-operation
    iss_alloc = 1; iss_wa = 4;
    tick();
    iss_wa = 8;
    tick();
    iss_alloc = 0;
    lu_valid = 1; lu_wa = 4; lu_wd = 32'hBEEF;
    pl_we = 1; pl_wa = 6; pl_wd = 32'h6666;
    tick();
    q_ra1 = 4; q_ra2 = 8;
    #1 chk_vec("t6_stall_before", iss_stall, 1);
    chk_vec("t6_rf_we_before", rf_we, 1);
    #1 reset = 1;
    #1;
    chk_vec("t6_rf_we", rf_we, 0);
    chk_vec("t6_rf_wa", rf_wa, 0);
    chk_vec("t6_rf_wd", rf_wd, 0);
    chk_vec("t6_iss_stall", iss_stall, 0);
    chk_vec("t6_pl_hold", pl_hold, 0);
    chk_vec("t6_proto_err", proto_err, 0);
    pl_we = 0; lu_valid = 0;
    #2 reset = 0;
    tick();
    q_ra1 = 13; q_ra2 = 8;
    #1 chk_vec("t6_pending_cleared", iss_stall, 0);
    chk_vec("t6_rf_we_idle", rf_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
